// File: rtl/ref_sample_addr_arbiter.sv
// Selects one intra-prediction address generator per block and forwards its
// address/enables to the top/left reference-sample RAM ports, one clock late.
module ref_sample_addr_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SEL_W-1:0]            mode_sel,
  input  logic [CNT_W-1:0]            num_access,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]          src_en_top,
  input  logic [NUM_SRC-1:0]          src_en_left,
  output logic [ADDR_W-1:0]           address_RAM,
  output logic                        en_top,
  output logic                        en_left,
  output logic                        busy,
  output logic                        done,
  output logic                        err_conflict
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic               en_top_reg, en_top_next;
  logic               en_left_reg, en_left_next;
  logic               err_reg, err_next;

  logic [NUM_SRC-1:0] sel_onehot;
  logic [NUM_SRC-1:0] other_en;
  logic [ADDR_W-1:0]  masked_addr [NUM_SRC];
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_en_top;
  logic               sel_en_left;
  logic               access;
  logic               mode_valid;

  // Per-source decode: AND-OR mux keyed by the latched select, plus a
  // conflict flag for every source that is not the selected one.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign sel_onehot[gi]  = (sel_reg == SEL_W'(gi));
      assign masked_addr[gi] = src_addr[gi*ADDR_W +: ADDR_W] & {ADDR_W{sel_onehot[gi]}};
      assign other_en[gi]    = ~sel_onehot[gi] & (src_en_top[gi] | src_en_left[gi]);
    end
  endgenerate

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_addr = sel_addr | masked_addr[i];
    end
  end

  assign sel_en_top  = |(src_en_top  & sel_onehot);
  assign sel_en_left = |(src_en_left & sel_onehot);
  // A counter at zero means the block is exhausted; never count or forward.
  assign access      = (sel_en_top | sel_en_left) && (cnt_reg != '0);
  assign mode_valid  = (int'(mode_sel) < NUM_SRC);

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    en_top_next  = 1'b0;
    en_left_next = 1'b0;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (start && mode_valid) begin
          sel_next   = mode_sel;
          cnt_next   = num_access;
          err_next   = 1'b0;
          state_next = (num_access == '0) ? FLUSH : RUN;
        end
      end

      RUN: begin
        addr_next = sel_addr;
        if (cnt_reg != '0) begin
          en_top_next  = sel_en_top;
          en_left_next = sel_en_left;
        end
        if (access) begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_next = FLUSH;
          end
        end
        if (|other_en) begin
          err_next = 1'b1;
        end
      end

      FLUSH: begin
        // Last access is already on the outputs; drop enables on the way out.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      en_top_reg  <= 1'b0;
      en_left_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      en_top_reg  <= en_top_next;
      en_left_reg <= en_left_next;
      err_reg     <= err_next;
    end
  end

  assign address_RAM  = addr_reg;
  assign en_top       = en_top_reg;
  assign en_left      = en_left_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FLUSH);
  assign err_conflict = err_reg;

endmodule

// File: tb/tb_ref_sample_addr_arbiter.sv
// Scoreboard bench: each task pushes the expected output word per cycle and
// pops it one clock later to compare against the arbiter outputs.
module tb_ref_sample_addr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default build (3 sources, 8-bit address)
  logic        start;
  logic [1:0]  mode_sel;
  logic [6:0]  num_access;
  logic [23:0] src_addr;
  logic [2:0]  src_en_top;
  logic [2:0]  src_en_left;
  logic [7:0]  address_RAM;
  logic        en_top, en_left, busy, done, err_conflict;

  // Wide build (5 sources, 10-bit address)
  logic        start5;
  logic [2:0]  mode_sel5;
  logic [6:0]  num_access5;
  logic [49:0] src_addr5;
  logic [4:0]  src_en_top5;
  logic [4:0]  src_en_left5;
  logic [9:0]  address_RAM5;
  logic        en_top5, en_left5, busy5, done5, err_conflict5;

  ref_sample_addr_arbiter dut (
    .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel),
    .num_access(num_access), .src_addr(src_addr), .src_en_top(src_en_top),
    .src_en_left(src_en_left), .address_RAM(address_RAM), .en_top(en_top),
    .en_left(en_left), .busy(busy), .done(done), .err_conflict(err_conflict)
  );

  ref_sample_addr_arbiter #(.ADDR_W(10), .NUM_SRC(5), .SEL_W(3), .CNT_W(7)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .mode_sel(mode_sel5),
    .num_access(num_access5), .src_addr(src_addr5), .src_en_top(src_en_top5),
    .src_en_left(src_en_left5), .address_RAM(address_RAM5), .en_top(en_top5),
    .en_left(en_left5), .busy(busy5), .done(done5), .err_conflict(err_conflict5)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [14:0] exp_q[$];

  // Output word: {busy, done, err, en_top, en_left, addr[9:0]}
  function automatic logic [14:0] pk(input int b, input int d, input int e,
                                     input int t, input int l, input int a);
    return {b[0], d[0], e[0], t[0], l[0], a[9:0]};
  endfunction

  function automatic logic [14:0] obs3();
    return {busy, done, err_conflict, en_top, en_left, 2'b00, address_RAM};
  endfunction

  function automatic logic [14:0] obs5();
    return {busy5, done5, err_conflict5, en_top5, en_left5, address_RAM5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst          = 1'b0;
    start        = 1'b0;
    mode_sel     = 2'd0;
    num_access   = 7'd0;
    src_addr     = {8'hE2, 8'hE1, 8'hE0};
    src_en_top   = 3'b000;
    src_en_left  = 3'b000;
    start5       = 1'b0;
    mode_sel5    = 3'd0;
    num_access5  = 7'd0;
    src_addr5    = {10'h3E4, 10'h3E3, 10'h3E2, 10'h3E1, 10'h3E0};
    src_en_top5  = 5'b00000;
    src_en_left5 = 5'b00000;
  endtask

  task automatic set_src(input int i, input int a, input int t, input int l);
    src_addr[i*8 +: 8] = a[7:0];
    src_en_top[i]      = t[0];
    src_en_left[i]     = l[0];
  endtask

  task automatic set_src5(input int i, input int a, input int t, input int l);
    src_addr5[i*10 +: 10] = a[9:0];
    src_en_top5[i]        = t[0];
    src_en_left5[i]       = l[0];
  endtask

  task automatic test_reset();
    logic [14:0] got, want;
    clear_inputs();
    rst = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    tick();
    tick();
    got = obs3(); want = exp_q.pop_front(); tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL reset_dut3 got=%h want=%h", got, want);
    end
    got = obs5(); want = exp_q.pop_front(); tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL reset_dut5 got=%h want=%h", got, want);
    end
    rst = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    tick();
    got = obs3(); want = exp_q.pop_front(); tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL reset_release got=%h want=%h", got, want);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_angular();
    logic [14:0] got, want;
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      case (c)
        0: begin start = 1'b1; mode_sel = 2'd1; num_access = 7'd4;
                 exp_q.push_back(pk(1, 0, 0, 0, 0, 0)); end
        1: begin set_src(1, 10, 1, 0); exp_q.push_back(pk(1, 0, 0, 1, 0, 10)); end
        2: begin set_src(1, 11, 1, 0); exp_q.push_back(pk(1, 0, 0, 1, 0, 11)); end
        3: begin set_src(1, 12, 1, 0); exp_q.push_back(pk(1, 0, 0, 1, 0, 12)); end
        4: begin set_src(1, 13, 1, 0); exp_q.push_back(pk(1, 1, 0, 1, 0, 13)); end
        default: exp_q.push_back(pk(0, 0, 0, 0, 0, 13));
      endcase
      tick();
      got = obs3(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL angular c%0d got=%h want=%h", c, got, want);
      end
    end
    $display("[TB] angular block of 4 accesses checked");
  endtask

  task automatic test_isolation();
    logic [14:0] got, want;
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      case (c)
        0: begin start = 1'b1; mode_sel = 2'd0; num_access = 7'd2;
                 exp_q.push_back(pk(1, 0, 0, 0, 0, 13)); end
        1: begin set_src(0, 8'h20, 1, 0); set_src(2, 8'h55, 0, 1);
                 exp_q.push_back(pk(1, 0, 1, 1, 0, 8'h20)); end
        2: begin set_src(0, 8'h21, 0, 1); exp_q.push_back(pk(1, 1, 1, 0, 1, 8'h21)); end
        3: exp_q.push_back(pk(0, 0, 1, 0, 0, 8'h21));
        4: begin start = 1'b1; mode_sel = 2'd1; num_access = 7'd0;
                 exp_q.push_back(pk(1, 1, 0, 0, 0, 8'h21)); end
        default: exp_q.push_back(pk(0, 0, 0, 0, 0, 8'h21));
      endcase
      tick();
      got = obs3(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL isolation c%0d got=%h want=%h", c, got, want);
      end
    end
    $display("[TB] mode isolation and zero-length block checked");
  endtask

  task automatic test_invalid_mode();
    logic [14:0] got, want;
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      set_src(2, 8'h77, 1, 0);
      if (c == 0) begin
        start = 1'b1; mode_sel = 2'd3; num_access = 7'd2;
      end
      exp_q.push_back(pk(0, 0, 0, 0, 0, 8'h21));
      tick();
      got = obs3(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL invalid_mode c%0d got=%h want=%h", c, got, want);
      end
    end
    $display("[TB] out-of-range mode_sel checked");
  endtask

  task automatic test_back_to_back();
    logic [14:0] got, want;
    for (int c = 0; c < 9; c++) begin
      clear_inputs();
      case (c)
        0: begin start = 1'b1; mode_sel = 2'd1; num_access = 7'd3;
                 exp_q.push_back(pk(1, 0, 0, 0, 0, 8'h21)); end
        1: begin start = 1'b1; mode_sel = 2'd2; num_access = 7'd1;
                 set_src(1, 8'h30, 1, 0); exp_q.push_back(pk(1, 0, 0, 1, 0, 8'h30)); end
        2: begin set_src(1, 8'h31, 0, 0); exp_q.push_back(pk(1, 0, 0, 0, 0, 8'h31)); end
        3: begin set_src(1, 8'h32, 1, 0); exp_q.push_back(pk(1, 0, 0, 1, 0, 8'h32)); end
        4: begin set_src(1, 8'h33, 0, 1); exp_q.push_back(pk(1, 1, 0, 0, 1, 8'h33)); end
        5: begin start = 1'b1; mode_sel = 2'd0; num_access = 7'd0;
                 exp_q.push_back(pk(0, 0, 0, 0, 0, 8'h33)); end
        6: begin start = 1'b1; mode_sel = 2'd2; num_access = 7'd1;
                 exp_q.push_back(pk(1, 0, 0, 0, 0, 8'h33)); end
        7: begin set_src(2, 8'h44, 1, 0); exp_q.push_back(pk(1, 1, 0, 1, 0, 8'h44)); end
        default: exp_q.push_back(pk(0, 0, 0, 0, 0, 8'h44));
      endcase
      tick();
      got = obs3(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL back_to_back c%0d got=%h want=%h", c, got, want);
      end
    end
    $display("[TB] busy protection and back-to-back blocks checked");
  endtask

  task automatic test_mid_reset();
    logic [14:0] got, want;
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      case (c)
        0: begin start = 1'b1; mode_sel = 2'd2; num_access = 7'd5;
                 exp_q.push_back(pk(1, 0, 0, 0, 0, 8'h44)); end
        1: begin set_src(2, 8'h50, 1, 0); exp_q.push_back(pk(1, 0, 0, 1, 0, 8'h50)); end
        2: begin set_src(2, 8'h51, 1, 0); exp_q.push_back(pk(1, 0, 0, 1, 0, 8'h51)); end
        3: begin rst = 1'b1; set_src(2, 8'h52, 1, 0); exp_q.push_back(pk(0, 0, 0, 0, 0, 0)); end
        4: begin set_src(2, 8'h53, 1, 0); exp_q.push_back(pk(0, 0, 0, 0, 0, 0)); end
        5: begin start = 1'b1; mode_sel = 2'd0; num_access = 7'd1;
                 exp_q.push_back(pk(1, 0, 0, 0, 0, 0)); end
        6: begin set_src(0, 8'h60, 1, 0); exp_q.push_back(pk(1, 1, 0, 1, 0, 8'h60)); end
        default: exp_q.push_back(pk(0, 0, 0, 0, 0, 8'h60));
      endcase
      tick();
      got = obs3(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL mid_reset c%0d got=%h want=%h", c, got, want);
      end
    end
    $display("[TB] mid-block reset checked");
  endtask

  task automatic test_param_build();
    logic [14:0] got, want;
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      case (c)
        0: begin start5 = 1'b1; mode_sel5 = 3'd4; num_access5 = 7'd3;
                 exp_q.push_back(pk(1, 0, 0, 0, 0, 0)); end
        1: begin set_src5(4, 1023, 1, 0); exp_q.push_back(pk(1, 0, 0, 1, 0, 1023)); end
        2: begin set_src5(4, 0, 0, 1); exp_q.push_back(pk(1, 0, 0, 0, 1, 0)); end
        3: begin set_src5(4, 512, 1, 1); exp_q.push_back(pk(1, 1, 0, 1, 1, 512)); end
        4: exp_q.push_back(pk(0, 0, 0, 0, 0, 512));
        default: begin start5 = 1'b1; mode_sel5 = 3'd5; num_access5 = 7'd2;
                       exp_q.push_back(pk(0, 0, 0, 0, 0, 512)); end
      endcase
      tick();
      got = obs5(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL param_build c%0d got=%h want=%h", c, got, want);
      end
    end
    $display("[TB] 5-source build checked");
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_angular();
    test_isolation();
    test_invalid_mode();
    test_back_to_back();
    test_mid_reset();
    test_param_build();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ref_sample_addr_arbiter.md
Name: ref_sample_addr_arbiter

Overview:
- Registered, parametrised selector between the intra-prediction address generators (DC, angular, planar, plus future modes) and the reference-sample RAM top/left ports.
- Latches the prediction mode once per block on a start pulse, forwards only that source's address and enables to the RAM, and counts accesses to detect the end of the block.
- Signals busy and done to the prediction controller, and flags any non-selected generator that drives its enables during a block.
- Sits between the per-mode address generators and the top/left reference RAMs.

Parameters:
- ADDR_W, 8: RAM address width.
- NUM_SRC, 3: number of address-generator sources. Index 0 = DC, 1 = angular, 2 = planar.
- SEL_W, 2: width of mode_sel. Must satisfy 2^SEL_W >= NUM_SRC.
- CNT_W, 7: width of the access counter and num_access.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: begin a prediction block.
- mode_sel  in  SEL_W  source index; sampled only when start is accepted.
- num_access  in  CNT_W  number of RAM accesses in the block; sampled with start.
- src_addr  in  NUM_SRC*ADDR_W  packed addresses. Source i occupies bits [i*ADDR_W +: ADDR_W].
- src_en_top  in  NUM_SRC  per-source top-RAM enable.
- src_en_left  in  NUM_SRC  per-source left-RAM enable.
- address_RAM  out  ADDR_W  registered RAM address.
- en_top  out  1  registered top-RAM enable.
- en_left  out  1  registered left-RAM enable.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  single-cycle end-of-block pulse.
- err_conflict  out  1  sticky: a non-selected source asserted an enable during RUN.

Behaviour:
- Reset: synchronous, takes priority over all inputs.
  - State goes to IDLE.
  - address_RAM, en_top, en_left, busy, done and err_conflict all go to 0.
  - Latched select and counter go to 0.
  - Reset mid-block abandons the block; no done pulse is produced.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - en_top = en_left = 0; address_RAM holds its last value.
  - start with mode_sel < NUM_SRC:
    - latch sel = mode_sel and cnt = num_access;
    - clear err_conflict;
    - go to RUN, or to FLUSH if num_access == 0.
  - start with mode_sel >= NUM_SRC: ignored; stay in IDLE, no done.
- RUN:
  - Every cycle, register the selected source's addr, en_top and en_left to the outputs. Latency from source to RAM port is exactly 1 clock.
  - A cycle counts as an access when the selected source's (en_top | en_left) = 1. On an access, cnt decrements by 1.
  - Access with cnt == 1: go to FLUSH. The last access appears on the outputs in the FLUSH cycle.
  - Enables of the selected source while cnt == 0 are never forwarded.
- FLUSH:
  - Lasts one cycle. done = 1 and busy = 1; outputs carry the last registered access.
  - Next cycle: IDLE, with en_top = en_left = 0 and done = 0.
  - For num_access == 0, FLUSH carries en = 0 and no RAM access occurs.
- start while busy (RUN or FLUSH): ignored, with no effect on sel or cnt. start in the cycle after done is accepted normally, giving back-to-back blocks with one idle cycle between them.
- err_conflict: set in RUN when any source j != sel asserts src_en_top[j] or src_en_left[j]. Cleared only by rst or by an accepted start. The conflicting source is never forwarded.
- Counter: unsigned CNT_W bits; it never wraps below 0.
- Source switching: mode_sel changes outside an accepted start have no effect, so there is never a mid-block mode switch.

Test Plan:
- Angular block: start with mode_sel=1, num_access=4; source 1 drives addr 10,11,12,13 with en_top=1 on four consecutive cycles. Required: address_RAM = 10..13 one cycle later with en_top=1; done pulses with addr 13 on the outputs; en_top=0 on the following cycle.
- Mode isolation: start with mode_sel=0 (DC), num_access=2; source 2 asserts src_en_left mid-block. Required: err_conflict=1 and held; outputs carry only source 0 values; err_conflict is cleared by the next accepted start.
- Boundaries, one case each:
  - num_access=0 gives done on the cycle after start, with en outputs never high.
  - mode_sel=3 with NUM_SRC=3 is ignored: busy stays 0.
- Busy protection: a second start with mode_sel=2 during RUN leaves sel=1 and cnt unaffected. A start on the cycle after done is accepted.
- Mid-block reset: rst asserted after 2 of 5 accesses. Required: next cycle all outputs 0 and state IDLE; no done pulse; a subsequent start behaves normally.
- Parametrised build: NUM_SRC=5, ADDR_W=10, start with mode_sel=4, num_access=3. Required: source 4's addresses (e.g. 1023, 0, 512) are forwarded correctly and done follows the third access.
